wait_state_mem_responder: RTL

Responder end of the CPU memory handshake: a single-port, word-organised memory model with a parameterised wait-state latency and byte-enable writes. It accepts one read or write request at a time and completes it with a one-cycle `resp` pulse after a fixed number of cycles. It substitutes for the zero-configuration memory beside `cpu` in simulation tops, so the CPU's stall and handshake logic runs against realistic, multi-cycle responses.

---
 rtl/wait_state_mem_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/wait_state_mem_responder.sv
// Word-organised memory responder with a fixed wait-state latency and byte-enable writes.
// Accepts one request at a time and completes it with a single-cycle resp pulse.
module wait_state_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        resp,
    output logic [31:0] rdata,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic            op_write;
    logic [AW-1:0]   idx;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            txn_write;
    logic [AW-1:0]   txn_idx;
    logic [31:0]     txn_wdata;
    logic [3:0]      txn_be;
    logic            commit;
    logic            unused_addr;

    assign unused_addr = ^{address[31:AW+2], address[1:0]};

    // With LATENCY=1 the commit happens at the sampling edge, before the latch holds anything.
    assign txn_write = (state == IDLE) ? write                : op_write;
    assign txn_idx   = (state == IDLE) ? address[AW+1:2]      : idx;
    assign txn_wdata = (state == IDLE) ? wdata                : wdata_q;
    assign txn_be    = (state == IDLE) ? byte_enable          : be_q;
    assign commit    = rst_n && (state_n == RESP);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (read || write) begin
                    if (LAT_M1 == 4'd0) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) state_n = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write <= 1'b0;
            idx      <= '0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
        end else if (state == IDLE && (read || write)) begin
            op_write <= write;
            idx      <= address[AW+1:2];
            wdata_q  <= wdata;
            be_q     <= byte_enable;
        end
    end

    // Write wins when read and write arrive together, so rdata is left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= 32'd0;
        else if (commit && !txn_write) rdata <= mem[txn_idx];
    end

    always_ff @(posedge clk) begin
        if (commit && txn_write) begin
            for (int i = 0; i < 4; i++) begin
                if (txn_be[i]) mem[txn_idx][8*i +: 8] <= txn_wdata[8*i +: 8];
            end
        end
    end

    assign resp = (state == RESP);
    assign busy = (state != IDLE);
endmodule
